alu_uart_sequencer: RTL and testbench

Controller between the UART receiver/transmitter and the combinational ALU in top_arquitectura. It collects three received bytes in order (operand A, opcode, operand B) and drives them onto the ALU inputs. It then captures the ALU result and hands it to the UART transmitter, waiting for transmit completion before accepting a new frame. An inter-byte timeout resynchronises the sequence when a partial frame is abandoned.

---
 rtl/alu_uart_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer between a UART and a combinational ALU: it collects operand A,
// the opcode and operand B, launches one transmit of the ALU result and waits for TX completion.
module alu_uart_sequencer #(
    parameter int BUS_DATOS_ALU   = 8,
    parameter int BUS_SALIDA_ALU  = 8,
    parameter int CANT_BIT_OPCODE = 8,
    parameter int WIDTH_WORD_TOP  = 8,
    parameter int TIMEOUT_CYCLES  = 1145870
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_rx_done,
    input  logic [WIDTH_WORD_TOP-1:0]  i_rx_data,
    input  logic [BUS_SALIDA_ALU-1:0]  i_alu_result,
    input  logic                       i_tx_done,
    output logic [BUS_DATOS_ALU-1:0]   o_data_a,
    output logic [BUS_DATOS_ALU-1:0]   o_data_b,
    output logic [CANT_BIT_OPCODE-1:0] o_opcode,
    output logic [BUS_SALIDA_ALU-1:0]  o_tx_data,
    output logic                       o_tx_start,
    output logic                       o_busy,
    output logic                       o_timeout,
    output logic                       o_overrun
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ESPERA_A,
        ESPERA_OP,
        ESPERA_B,
        CALCULO,
        ESPERA_TX
    } state_t;

    state_t                     r_state, w_state_next;
    logic [CNT_W-1:0]           r_count, w_count_next;
    logic [BUS_DATOS_ALU-1:0]   r_data_a, w_data_a_next;
    logic [BUS_DATOS_ALU-1:0]   r_data_b, w_data_b_next;
    logic [CANT_BIT_OPCODE-1:0] r_opcode, w_opcode_next;
    logic [BUS_SALIDA_ALU-1:0]  r_tx_data, w_tx_data_next;
    logic                       r_tx_start, w_tx_start_next;
    logic                       r_timeout, w_timeout_next;
    logic                       r_overrun, w_overrun_next;

    // NOTE: every signal gets its default first so no path through the case below infers a latch.
    always_comb begin
        w_state_next    = r_state;
        w_count_next    = '0;
        w_data_a_next   = r_data_a;
        w_data_b_next   = r_data_b;
        w_opcode_next   = r_opcode;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_timeout_next  = 1'b0;
        w_overrun_next  = r_overrun;

        case (r_state)
            ESPERA_A: begin
                if (i_rx_done) begin
                    w_data_a_next  = i_rx_data[BUS_DATOS_ALU-1:0];
                    w_overrun_next = 1'b0;
                    w_state_next   = ESPERA_OP;
                end
            end
            ESPERA_OP: begin
                if (i_rx_done) begin
                    w_opcode_next = i_rx_data[CANT_BIT_OPCODE-1:0];
                    w_state_next  = ESPERA_B;
                end else if (r_count == CNT_LAST) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ESPERA_A;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            ESPERA_B: begin
                if (i_rx_done) begin
                    w_data_b_next = i_rx_data[BUS_DATOS_ALU-1:0];
                    w_state_next  = CALCULO;
                end else if (r_count == CNT_LAST) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ESPERA_A;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            CALCULO: begin
                // Operands settled last edge, so the ALU output is stable here.
                w_tx_data_next  = i_alu_result;
                w_tx_start_next = 1'b1;
                w_overrun_next  = r_overrun | i_rx_done;
                w_state_next    = ESPERA_TX;
            end
            ESPERA_TX: begin
                w_overrun_next = r_overrun | i_rx_done;
                if (i_tx_done) begin
                    w_state_next = ESPERA_A;
                end
            end
            default: w_state_next = ESPERA_A;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ESPERA_A;
            r_count    <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_opcode   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_data_a   <= w_data_a_next;
            r_data_b   <= w_data_b_next;
            r_opcode   <= w_opcode_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_timeout  <= w_timeout_next;
            r_overrun  <= w_overrun_next;
        end
    end

    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_opcode   = r_opcode;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_timeout  = r_timeout;
    assign o_overrun  = r_overrun;
    assign o_busy     = (r_state == CALCULO) || (r_state == ESPERA_TX);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer: directed scenarios plus randomized frames,
// compared every cycle against a transaction-level model of the frame protocol.
module tb_alu_uart_sequencer;

    localparam int TMO = 100;

    logic       i_clock;
    logic       i_reset;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_data_a, o_data_b, o_opcode, o_tx_data;
    logic       o_tx_start, o_busy, o_timeout, o_overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Model: bytes gathered in the current frame, idle cycles since the last byte,
    // and the busy phase (0 = collecting, 1 = compute cycle, 2 = transmitting).
    int         m_got, m_idle, m_phase;
    logic [7:0] m_a, m_op, m_b, m_tx;
    logic       m_start, m_timeout, m_ovr;

    alu_uart_sequencer #(
        .BUS_DATOS_ALU  (8),
        .BUS_SALIDA_ALU (8),
        .CANT_BIT_OPCODE(8),
        .WIDTH_WORD_TOP (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_data_a    (o_data_a),
        .o_data_b    (o_data_b),
        .o_opcode    (o_opcode),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_overrun   (o_overrun)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            8'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_f(o_data_a, o_opcode, o_data_b);

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic rx, input logic [7:0] rxd, input logic tx);
        m_start   = 1'b0;
        m_timeout = 1'b0;
        if (rst) begin
            {m_a, m_op, m_b, m_tx, m_ovr} = '0;
            m_got = 0; m_idle = 0; m_phase = 0;
        end else if (m_phase == 0) begin
            if (rx) begin
                if (m_got == 0) begin m_a = rxd; m_ovr = 1'b0; end
                else if (m_got == 1) m_op = rxd;
                else m_b = rxd;
                m_got++;
                m_idle = 0;
                if (m_got == 3) begin m_got = 0; m_phase = 1; end
            end else if (m_got > 0) begin
                m_idle++;
                if (m_idle == TMO) begin m_got = 0; m_idle = 0; m_timeout = 1'b1; end
            end
        end else if (m_phase == 1) begin
            m_tx    = alu_f(m_a, m_op, m_b);
            m_start = 1'b1;
            m_phase = 2;
            if (rx) m_ovr = 1'b1;
        end else begin
            if (rx) m_ovr = 1'b1;
            if (tx) m_phase = 0;
        end
    endtask

    // One clock: present inputs, advance the model, then compare all outputs after the edge.
    task automatic step(input logic rst, input logic rx, input logic [7:0] rxd, input logic tx);
        i_reset = rst; i_rx_done = rx; i_rx_data = rxd; i_tx_done = tx;
        model_edge(rst, rx, rxd, tx);
        @(posedge i_clock);
        #1;
        check("busy",     o_busy,     m_phase != 0);
        check("tx_start", o_tx_start, m_start);
        check("timeout",  o_timeout,  m_timeout);
        check("overrun",  o_overrun,  m_ovr);
        check("data_a",   o_data_a,   m_a);
        check("opcode",   o_opcode,   m_op);
        check("data_b",   o_data_b,   m_b);
        check("tx_data",  o_tx_data,  m_tx);
        i_reset = 1'b0; i_rx_done = 1'b0; i_tx_done = 1'b0; i_rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic tx_pulse();
        step(1'b0, 1'b0, 8'($urandom), 1'b1);
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 8'h20;
            1: return 8'h22;
            2: return 8'h24;
            3: return 8'h25;
            4: return 8'h26;
            5: return 8'h27;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = '0; i_tx_done = 1'b0;
        m_got = 0; m_idle = 0; m_phase = 0;
        {m_a, m_op, m_b, m_tx, m_start, m_timeout, m_ovr} = '0;

        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_data_a", o_data_a, 8'h00);

        // ADD frame, TX completes 50 cycles after the start pulse
        rx_byte(8'h05); idle(3); rx_byte(8'h20); rx_byte(8'h03);
        check("t1_a", o_data_a, 8'h05);
        check("t1_op", o_opcode, 8'h20);
        check("t1_b", o_data_b, 8'h03);
        check("t1_start_early", o_tx_start, 1'b0);
        idle(1);
        check("t1_start", o_tx_start, 1'b1);
        check("t1_tx_data", o_tx_data, 8'h08);
        idle(49);
        tx_pulse();
        check("t1_busy_after_done", o_busy, 1'b0);

        // Abandoned frame times out after TMO idle cycles
        rx_byte(8'h0A); idle(TMO - 1);
        check("t2_no_timeout_yet", o_timeout, 1'b0);
        idle(1);
        check("t2_timeout", o_timeout, 1'b1);
        idle(1);
        check("t2_timeout_pulse", o_timeout, 1'b0);
        rx_byte(8'h01); rx_byte(8'h20); rx_byte(8'h01); idle(1);
        check("t2_tx_data", o_tx_data, 8'h02);
        tx_pulse();

        // Opcode arriving on the expiry cycle wins over the timeout; TX done with the start pulse
        rx_byte(8'h0A); idle(TMO - 1); rx_byte(8'h22);
        check("t3_no_timeout", o_timeout, 1'b0);
        check("t3_opcode", o_opcode, 8'h22);
        rx_byte(8'h01); idle(1); tx_pulse();
        check("t3_done_same_cycle", o_busy, 1'b0);

        // Byte during TX is an overrun; the next operand A clears it
        rx_byte(8'h11); rx_byte(8'h24); rx_byte(8'h0F); idle(1);
        rx_byte(8'hFF);
        check("t4_overrun", o_overrun, 1'b1);
        check("t4_a_kept", o_data_a, 8'h11);
        tx_pulse(); rx_byte(8'h33);
        check("t4_overrun_clear", o_overrun, 1'b0);
        rx_byte(8'h26); rx_byte(8'h0F); idle(1); tx_pulse();

        // Reset between byte B and the start pulse abandons the frame
        rx_byte(8'h01); rx_byte(8'h20); rx_byte(8'h02);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("t5_start", o_tx_start, 1'b0);
        check("t5_b", o_data_b, 8'h00);
        idle(5);
        rx_byte(8'h07); rx_byte(8'h25); rx_byte(8'h30); idle(1);
        check("t5_fresh_tx", o_tx_data, 8'h37);
        tx_pulse();

        // TX done while idle is ignored
        tx_pulse(); tx_pulse();
        check("t6_busy", o_busy, 1'b0);

        // Randomized frames: gaps sometimes straddle the timeout, overruns and resets sprinkled in
        for (int f = 0; f < 60; f++) begin
            for (int k = 0; k < 3; k++) begin
                int gap;
                gap = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO - 2, TMO + 1))
                                                 : int'($urandom_range(0, 6));
                idle(gap);
                rx_byte(k == 1 ? rand_op() : 8'($urandom));
            end
            if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 8'h00, 1'b0);
            step(1'b0, $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
            for (int d = $urandom_range(0, 12); d > 0; d--)
                step(1'b0, $urandom_range(0, 4) == 0, 8'($urandom), 1'b0);
            step(1'b0, $urandom_range(0, 3) == 0, 8'($urandom), 1'b1);
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
